// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - value encoding, FSM state type and value packing for the variable store
package sat_pkg;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;
  localparam int         IMPLIED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BKT  = 2'd2
  } state_t;

  function automatic logic [2:0] mk_value(input logic implied, input logic [1:0] val);
    logic [2:0] v;
    v = {1'b0, val};
    v[IMPLIED_BIT] = implied;
    return v;
  endfunction

endpackage

// File: rtl/var_state_cell.sv
// rtl/var_state_cell.sv - one variable's value/level register with update and conflict logic
module var_state_cell
  import sat_pkg::*;
#(
  parameter int WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_we,
  input  logic [2:0]           i_load_value,
  input  logic [WIDTH_LVL-1:0] i_load_lvl,
  input  logic                 i_clr_we,
  input  logic [WIDTH_LVL-1:0] i_bkt_lvl,
  input  logic                 i_dec_we,
  input  logic [WIDTH_LVL-1:0] i_cur_lvl,
  input  logic                 i_imply_we,
  input  logic [1:0]           i_imply_value,
  output logic [2:0]           o_value,
  output logic [WIDTH_LVL-1:0] o_lvl,
  output logic                 o_conflict
);

  logic [2:0]           r_value;
  logic [WIDTH_LVL-1:0] r_lvl;
  logic                 w_imply_legal;
  logic                 w_free;

  assign w_imply_legal = (i_imply_value == VAL_FALSE) || (i_imply_value == VAL_TRUE);
  assign w_free        = (r_value[1:0] == VAL_FREE);
  assign o_conflict    = i_imply_we && w_imply_legal && !w_free && (r_value[1:0] != i_imply_value);
  assign o_value       = r_value;
  assign o_lvl         = r_lvl;

  // Enables arrive already prioritised by the parent; the else-chain only orders them defensively.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_value <= '0;
      r_lvl   <= '0;
    end else if (i_load_we) begin
      r_value <= i_load_value;
      r_lvl   <= i_load_lvl;
    end else if (i_clr_we) begin
      if (r_lvl > i_bkt_lvl) begin
        r_value <= '0;
        r_lvl   <= '0;
      end
    end else if (i_dec_we) begin
      r_value <= mk_value(1'b0, VAL_FALSE);
      r_lvl   <= i_cur_lvl;
    end else if (i_imply_we && w_imply_legal && w_free) begin
      r_value <= mk_value(1'b1, i_imply_value);
      r_lvl   <= i_cur_lvl;
    end
  end

endmodule

// File: rtl/var_state_list.sv
// rtl/var_state_list.sv - per-variable assignment store with backtrack FSM and status reductions
module var_state_list
  import sat_pkg::*;
#(
  parameter int NUM_VARS      = 8,
  parameter int WIDTH_LVL     = 16,
  parameter int WIDTH_VAR_IDX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en_i,
  input  logic [WIDTH_VAR_IDX-1:0]      load_idx_i,
  input  logic [2:0]                    load_value_i,
  input  logic [WIDTH_LVL-1:0]          load_lvl_i,
  input  logic [NUM_VARS-1:0]           index_decided_i,
  input  logic                          decision_done_i,
  input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
  input  logic                          imply_en_i,
  input  logic [NUM_VARS-1:0]           imply_mask_i,
  input  logic [NUM_VARS*2-1:0]         imply_value_i,
  input  logic                          apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]          bkt_lvl_i,
  output logic [NUM_VARS*3-1:0]         vars_value_o,
  output logic [NUM_VARS*WIDTH_LVL-1:0] vars_lvl_o,
  output logic                          conflict_o,
  output logic                          all_assigned_o,
  output logic                          bkt_done_o
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH_LVL-1:0] r_bkt_lvl;
  logic                 r_conflict;
  logic                 r_bkt_done;

  logic                 w_bkt_req;
  logic                 w_bkt_clr;
  logic                 w_dec;
  logic                 w_imp;
  logic [NUM_VARS-1:0]  w_load_we;
  logic [NUM_VARS-1:0]  w_cell_conflict;
  logic [NUM_VARS-1:0]  w_assigned;

  // Priority load > backtrack > decision > implication; a winner suppresses every lower event.
  assign w_bkt_req = (r_state == ST_RUN) && apply_bkt_i && !load_en_i;
  assign w_bkt_clr = (r_state == ST_BKT) && !load_en_i;
  assign w_dec     = decision_done_i && !load_en_i && !w_bkt_req && (r_state != ST_BKT);
  assign w_imp     = imply_en_i && !load_en_i && !w_bkt_req && (r_state != ST_BKT) && !decision_done_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (load_en_i || decision_done_i) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_bkt_req) w_state_nxt = ST_BKT;
      ST_BKT:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bkt_lvl  <= '0;
      r_conflict <= 1'b0;
      r_bkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bkt_done <= (r_state == ST_BKT);
      if (w_bkt_req) begin
        r_bkt_lvl  <= bkt_lvl_i;
        r_conflict <= 1'b0;
      end else if (|w_cell_conflict) begin
        r_conflict <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VARS; gi++) begin : g_cell
      assign w_load_we[gi] = load_en_i && (load_idx_i == WIDTH_VAR_IDX'(gi));

      var_state_cell #(
        .WIDTH_LVL (WIDTH_LVL)
      ) u_cell (
        .clk           (clk),
        .rst           (rst),
        .i_load_we     (w_load_we[gi]),
        .i_load_value  (load_value_i),
        .i_load_lvl    (load_lvl_i),
        .i_clr_we      (w_bkt_clr),
        .i_bkt_lvl     (r_bkt_lvl),
        .i_dec_we      (w_dec && index_decided_i[gi]),
        .i_cur_lvl     (cur_lvl_i),
        .i_imply_we    (w_imp && imply_mask_i[gi]),
        .i_imply_value (imply_value_i[2*gi +: 2]),
        .o_value       (vars_value_o[3*gi +: 3]),
        .o_lvl         (vars_lvl_o[WIDTH_LVL*gi +: WIDTH_LVL]),
        .o_conflict    (w_cell_conflict[gi])
      );

      assign w_assigned[gi] = (vars_value_o[3*gi +: 2] != VAL_FREE);
    end
  endgenerate

  assign conflict_o     = r_conflict;
  assign all_assigned_o = &w_assigned;
  assign bkt_done_o     = r_bkt_done;

endmodule

// File: tb/tb_var_state_list.sv
// tb/tb_var_state_list.sv - table-driven scoreboard bench for var_state_list
module tb_var_state_list;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en_i;
  logic [2:0]  load_idx_i;
  logic [2:0]  load_value_i;
  logic [15:0] load_lvl_i;
  logic [7:0]  index_decided_i;
  logic        decision_done_i;
  logic [15:0] cur_lvl_i;
  logic        imply_en_i;
  logic [7:0]  imply_mask_i;
  logic [15:0] imply_value_i;
  logic        apply_bkt_i;
  logic [15:0] bkt_lvl_i;
  logic [23:0] vars_value_o;
  logic [127:0] vars_lvl_o;
  logic        conflict_o;
  logic        all_assigned_o;
  logic        bkt_done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  var_state_list #(.NUM_VARS(8), .WIDTH_LVL(16), .WIDTH_VAR_IDX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_en_i       (load_en_i),
    .load_idx_i      (load_idx_i),
    .load_value_i    (load_value_i),
    .load_lvl_i      (load_lvl_i),
    .index_decided_i (index_decided_i),
    .decision_done_i (decision_done_i),
    .cur_lvl_i       (cur_lvl_i),
    .imply_en_i      (imply_en_i),
    .imply_mask_i    (imply_mask_i),
    .imply_value_i   (imply_value_i),
    .apply_bkt_i     (apply_bkt_i),
    .bkt_lvl_i       (bkt_lvl_i),
    .vars_value_o    (vars_value_o),
    .vars_lvl_o      (vars_lvl_o),
    .conflict_o      (conflict_o),
    .all_assigned_o  (all_assigned_o),
    .bkt_done_o      (bkt_done_o)
  );

  typedef struct {
    string       name;
    logic        ld;
    logic [2:0]  li;
    logic [2:0]  lv;
    logic [15:0] ll;
    logic        dd;
    logic [7:0]  idx;
    logic [15:0] cl;
    logic        ie;
    logic [7:0]  im;
    logic [15:0] iv;
    logic        bk;
    logic [15:0] bl;
    logic [23:0] ev;
    int          ci;
    logic [15:0] el;
    logic        ec;
    logic        ea;
  } vec_t;

  typedef struct {
    string       name;
    logic [23:0] ev;
    int          ci;
    logic [15:0] el;
    logic        ec;
    logic        ea;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t nv(input string n);
    vec_t v;
    v.name = n; v.ld = 0; v.li = 0; v.lv = 0; v.ll = 0;
    v.dd = 0; v.idx = 0; v.cl = 0; v.ie = 0; v.im = 0; v.iv = 0;
    v.bk = 0; v.bl = 0; v.ev = 0; v.ci = 0; v.el = 0; v.ec = 0; v.ea = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load_en_i = 0; load_idx_i = 0; load_value_i = 0; load_lvl_i = 0;
    decision_done_i = 0; index_decided_i = 0; cur_lvl_i = 0;
    imply_en_i = 0; imply_mask_i = 0; imply_value_i = 0;
    apply_bkt_i = 0; bkt_lvl_i = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    load_en_i = v.ld; load_idx_i = v.li; load_value_i = v.lv; load_lvl_i = v.ll;
    decision_done_i = v.dd; index_decided_i = v.idx; cur_lvl_i = v.cl;
    imply_en_i = v.ie; imply_mask_i = v.im; imply_value_i = v.iv;
    apply_bkt_i = v.bk; bkt_lvl_i = v.bl;
  endtask

  function automatic logic [15:0] lvl_of(input int i);
    return vars_lvl_o[16*i +: 16];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    exp_t e;

    rst = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_value", {8'h0, vars_value_o}, 32'h0);
    check("reset_lvl", {31'h0, |vars_lvl_o}, 32'h0);
    check("reset_conflict", {31'h0, conflict_o}, 32'h0);
    check("reset_all_assigned", {31'h0, all_assigned_o}, 32'h0);
    check("reset_bkt_done", {31'h0, bkt_done_o}, 32'h0);
    rst = 1;
    @(negedge clk);

    v = nv("load_var3");    v.ld = 1; v.li = 3; v.lv = 3'b010; v.ll = 2;
    v.ev = 24'h000400; v.ci = 3; v.el = 2; vecs.push_back(v);
    v = nv("decide_var2");  v.dd = 1; v.idx = 8'b0000_0100; v.cl = 5;
    v.ev = 24'h000440; v.ci = 2; v.el = 5; vecs.push_back(v);
    v = nv("imply_var4");   v.ie = 1; v.im = 8'b0001_0000; v.iv = 16'h0200; v.cl = 6;
    v.ev = 24'h006440; v.ci = 4; v.el = 6; vecs.push_back(v);
    v = nv("imply_conflict"); v.ie = 1; v.im = 8'b0001_0000; v.iv = 16'h0100; v.cl = 7;
    v.ev = 24'h006440; v.ci = 4; v.el = 6; v.ec = 1; vecs.push_back(v);
    v = nv("conflict_sticky");
    v.ev = 24'h006440; v.ci = 4; v.el = 6; v.ec = 1; vecs.push_back(v);
    v = nv("imply_illegal11"); v.ie = 1; v.im = 8'b0010_0000; v.iv = 16'h0C00; v.cl = 7;
    v.ev = 24'h006440; v.ci = 5; v.el = 0; v.ec = 1; vecs.push_back(v);
    v = nv("decide_zero_idx"); v.dd = 1; v.idx = 8'h00; v.cl = 9;
    v.ev = 24'h006440; v.ci = 0; v.el = 0; v.ec = 1; vecs.push_back(v);
    v = nv("load_beats_decide"); v.ld = 1; v.li = 0; v.lv = 3'b010; v.ll = 1;
    v.dd = 1; v.idx = 8'b0000_0010; v.cl = 8;
    v.ev = 24'h006442; v.ci = 1; v.el = 0; v.ec = 1; vecs.push_back(v);
    v = nv("decide_beats_imply"); v.dd = 1; v.idx = 8'b0000_0010; v.cl = 3;
    v.ie = 1; v.im = 8'b0010_0000; v.iv = 16'h0800;
    v.ev = 24'h00644A; v.ci = 1; v.el = 3; v.ec = 1; vecs.push_back(v);
    v = nv("imply_var5_false"); v.ie = 1; v.im = 8'b0010_0000; v.iv = 16'h0400; v.cl = 3;
    v.ev = 24'h02E44A; v.ci = 5; v.el = 3; v.ec = 1; vecs.push_back(v);
    v = nv("load_lvl_max");  v.ld = 1; v.li = 6; v.lv = 3'b010; v.ll = 16'hFFFF;
    v.ev = 24'h0AE44A; v.ci = 6; v.el = 16'hFFFF; v.ec = 1; vecs.push_back(v);
    v = nv("load_last_free"); v.ld = 1; v.li = 7; v.lv = 3'b001; v.ll = 4;
    v.ev = 24'h2AE44A; v.ci = 7; v.el = 4; v.ec = 1; v.ea = 1; vecs.push_back(v);
    v = nv("load_beats_bkt"); v.ld = 1; v.li = 0; v.lv = 3'b001; v.ll = 3; v.bk = 1; v.bl = 0;
    v.ev = 24'h2AE449; v.ci = 0; v.el = 3; v.ec = 1; v.ea = 1; vecs.push_back(v);
    v = nv("after_dropped_bkt");
    v.ev = 24'h2AE449; v.ci = 2; v.el = 5; v.ec = 1; v.ea = 1; vecs.push_back(v);

    foreach (vecs[k]) begin
      apply_vec(vecs[k]);
      e.name = vecs[k].name; e.ev = vecs[k].ev; e.ci = vecs[k].ci;
      e.el = vecs[k].el; e.ec = vecs[k].ec; e.ea = vecs[k].ea;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check({e.name, "_value"}, {8'h0, vars_value_o}, {8'h0, e.ev});
      check({e.name, "_lvl"}, {16'h0, lvl_of(e.ci)}, {16'h0, e.el});
      check({e.name, "_conflict"}, {31'h0, conflict_o}, {31'h0, e.ec});
      check({e.name, "_all_assigned"}, {31'h0, all_assigned_o}, {31'h0, e.ea});
    end
    idle_inputs();

    // Backtrack to level 3: levels 3,3,5,2,6,3,FFFF,4 -> vars 2,4,6,7 freed.
    apply_bkt_i = 1; bkt_lvl_i = 3;
    @(negedge clk);
    check("bkt_conflict_cleared", {31'h0, conflict_o}, 32'h0);
    check("bkt_done_early", {31'h0, bkt_done_o}, 32'h0);
    apply_bkt_i = 1; bkt_lvl_i = 0;
    decision_done_i = 1; index_decided_i = 8'b0000_0001; cur_lvl_i = 1;
    @(negedge clk);
    idle_inputs();
    check("bkt_done_pulse", {31'h0, bkt_done_o}, 32'h1);
    check("bkt_value", {8'h0, vars_value_o}, 32'h028409);
    check("bkt_lvl_var2", {16'h0, lvl_of(2)}, 32'h0);
    check("bkt_lvl_var6", {16'h0, lvl_of(6)}, 32'h0);
    check("bkt_lvl_equal_kept", {16'h0, lvl_of(5)}, 32'h3);
    check("bkt_decide_dropped", {16'h0, lvl_of(0)}, 32'h3);
    check("bkt_all_assigned", {31'h0, all_assigned_o}, 32'h0);
    @(negedge clk);
    check("bkt_done_one_cycle", {31'h0, bkt_done_o}, 32'h0);
    check("bkt_value_stable", {8'h0, vars_value_o}, 32'h028409);

    for (int i = 0; i < 8; i++) begin
      load_en_i = 1; load_idx_i = 3'(i); load_value_i = 3'b010; load_lvl_i = 16'(i + 1);
      @(negedge clk);
    end
    idle_inputs();
    check("fill_all_assigned", {31'h0, all_assigned_o}, 32'h1);
    check("fill_value", {8'h0, vars_value_o}, 32'h492492);
    check("fill_lvl_var7", {16'h0, lvl_of(7)}, 32'h8);

    apply_bkt_i = 1; bkt_lvl_i = 0;
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    check("rst_bkt_value", {8'h0, vars_value_o}, 32'h0);
    check("rst_bkt_lvl", {31'h0, |vars_lvl_o}, 32'h0);
    check("rst_bkt_done", {31'h0, bkt_done_o}, 32'h0);
    check("rst_bkt_all_assigned", {31'h0, all_assigned_o}, 32'h0);
    rst = 1;
    @(negedge clk);
    check("rst_bkt_no_pulse", {31'h0, bkt_done_o}, 32'h0);
    check("rst_bkt_value_held", {8'h0, vars_value_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/var_state_list.md
Name: var_state_list

Overview:
- Per-variable assignment store sitting directly downstream of the decision stage inside state_list.
- Holds the 3-bit value and the decision level of every variable in the current bin.
- Applies a decided variable on the decision-done pulse and applies implication masks from BCP.
- Clears assignments above the backtrack level.
- Feeds vars_value_o back to the decision stage and exports status (conflict, all-assigned) to the SAT-engine controller.

Parameters:
- NUM_VARS, 8, variables held in this bin.
- WIDTH_LVL, 16, decision-level width.
- WIDTH_VAR_IDX, 3, width of the serial load/unload index (log2 NUM_VARS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- load_en_i  in  1  serial load strobe, one variable per cycle
- load_idx_i  in  WIDTH_VAR_IDX  variable index being loaded
- load_value_i  in  3  value to load
- load_lvl_i  in  WIDTH_LVL  level to load
- index_decided_i  in  NUM_VARS  one-hot decided variable
- decision_done_i  in  1  one-cycle pulse qualifying index_decided_i
- cur_lvl_i  in  WIDTH_LVL  current decision level
- imply_en_i  in  1  implication strobe
- imply_mask_i  in  NUM_VARS  variables implied this cycle
- imply_value_i  in  NUM_VARS*2  implied value, 2 bits per variable
- apply_bkt_i  in  1  backtrack request pulse
- bkt_lvl_i  in  WIDTH_LVL  target backtrack level
- vars_value_o  out  NUM_VARS*3  {implied, val[1:0]} per variable
- vars_lvl_o  out  NUM_VARS*WIDTH_LVL  level per variable
- conflict_o  out  1  implication contradicted an assigned variable
- all_assigned_o  out  1  no free variable remains
- bkt_done_o  out  1  one-cycle pulse when backtrack is complete

Behaviour:
- Value encoding: val 2'b00 free, 2'b01 false, 2'b10 true, 2'b11 reserved/illegal. Bit 2 is the implied flag (1 = implied, 0 = decided).
- Reset (rst==0 at posedge): all values 3'b000, all levels 0, conflict_o 0, bkt_done_o 0, state IDLE.
- all_assigned_o is combinational: AND over (val != 00). It is 0 after reset.
- States:
  - IDLE → RUN on the first load_en_i or decision_done_i.
  - RUN → BKT on apply_bkt_i.
  - BKT → RUN after one cycle.
  - No other transitions.
- Load (any state): on load_en_i, variable load_idx_i takes load_value_i and load_lvl_i, one cycle latency. load_idx_i >= NUM_VARS is ignored.
- Decision: on decision_done_i, every variable with index_decided_i bit set gets value 3'b001 (decided, false) and level cur_lvl_i. Latency is 1 cycle.
  - An all-zero index_decided_i changes nothing.
  - A multi-hot index_decided_i is illegal; the implementation assigns all set bits.
- Implication: on imply_en_i, for each variable with its mask bit set:
  - If free: value becomes {1'b1, imply_value} and level becomes cur_lvl_i.
  - If assigned with the same val: no change.
  - If assigned with a different val: no change to that variable, and conflict_o is set.
  - An implied value of 00 or 11 is ignored.
- conflict_o is sticky. It clears only on reset or on entering BKT.
- Backtrack: apply_bkt_i in RUN moves to BKT.
  - In the BKT cycle, every variable with level > bkt_lvl_i becomes 3'b000 with level 0. Levels equal to bkt_lvl_i are kept.
  - bkt_lvl_i is captured on the apply_bkt_i cycle.
  - bkt_done_o pulses high in the cycle after BKT, concurrent with the return to RUN.
  - apply_bkt_i while already in BKT is ignored.
- Simultaneous events, priority load > backtrack > decision > implication:
  - A lower-priority event in the same cycle is dropped. Upstream guarantees exclusivity; the bench checks the priority anyway.
  - Decision and implication arriving in the BKT cycle are dropped.
- Level comparisons are unsigned, so a level of all-ones compares above every other level.
- Reset mid-backtrack returns to IDLE with everything cleared, and bkt_done_o is not emitted.

Decomposition:
- Shared package (sat_pkg): value-encoding constants VAL_FREE, VAL_FALSE, VAL_TRUE; IMPLIED_BIT index; FSM state typedef.
- One sub-module, var_state_cell: a single variable's value and level register plus its update and conflict logic. Instantiated NUM_VARS times by generate.
- The parent holds the FSM, the backtrack-level capture, and the conflict/all-assigned reductions.

Test Plan:
- Reset, then load var3 = 3'b010 at lvl 2 → vars_value_o[11:9] = 010 and vars_lvl_o for var3 = 2 one cycle later; all_assigned_o = 0.
- decision_done_i with index 8'b0000_0100, cur_lvl 5 → var2 = 3'b001 at lvl 5 next cycle; other variables unchanged.
- imply_mask 8'b0001_0000 with value 10 onto free var4 → var4 = 3'b110. Then the same mask with value 01 → var4 unchanged and conflict_o = 1, sticky.
- Vars at levels 1, 3, 3, 4, then apply_bkt_i with bkt_lvl 3 → after BKT only the level-4 variable is free; bkt_done_o is high exactly 2 cycles after apply_bkt_i; conflict_o is cleared.
- decision_done_i and load_en_i in the same cycle on different vars → only the load takes effect.
- Fill all 8 variables → all_assigned_o = 1. Assert rst during BKT → all zeros, and no bkt_done_o pulse.
